// File: rtl/scan_pkg.sv
// Shared definitions for the dot-matrix scanline capture block.
//   DEF_ROWS / DEF_COLS : default matrix geometry (8 rows x 16 columns)
//   scan_state_t        : capture FSM state encoding
//   frame_row_t         : one row of column data at the default width
package scan_pkg;

  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLING = 2'd1,
    CAPTURED = 2'd2
  } scan_state_t;

  typedef logic [DEF_COLS-1:0] frame_row_t;

endpackage

// File: rtl/onehot_row_decoder.sv
// Combinational decoder for an active-low one-hot row strobe.
//   row   in  ROWS         strobe, bit i low selects row i
//   valid out 1            exactly one bit low
//   blank out 1            no bit low
//   err   out 1            two or more bits low
//   idx   out $clog2(ROWS) index of the low bit (meaningful only when valid)
module onehot_row_decoder
  import scan_pkg::*;
#(
  parameter int ROWS = DEF_ROWS
) (
  input  logic [ROWS-1:0]         row,
  output logic                    valid,
  output logic                    blank,
  output logic                    err,
  output logic [$clog2(ROWS)-1:0] idx
);

  localparam int IW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS + 1);

  logic [CW-1:0] zeros;

  always_comb begin
    zeros = '0;
    idx   = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (!row[i]) begin
        zeros = zeros + CW'(1);
        idx   = i[IW-1:0];
      end
    end
  end

  assign valid = (zeros == CW'(1));
  assign blank = (zeros == '0);
  assign err   = (zeros > CW'(1));

endmodule

// File: rtl/dotmatrix_scan_capture.sv
// Receiving end of the dot-matrix scanline interface. Samples the row strobe
// and column data, captures each row once it has been stable for SETTLE
// cycles, and publishes a complete frame to a shadow buffer once every row
// has been seen.
//   clk         in  1      clock, all logic on posedge
//   rst         in  1      synchronous active-high reset
//   row         in  ROWS   active-low one-hot scan strobe
//   col         in  COLS   column data of the strobed row (1 = LED on)
//   rd_row      in  IW     shadow read address
//   rd_data     out COLS   shadow[rd_row], one cycle latency
//   frame_valid out 1      sticky: a full frame has been captured
//   frame_done  out 1      pulse after the shadow buffer was updated
//   row_err     out 1      pulse on first cycle of a multi-hot strobe
//   stale       out 1      no capture for TIMEOUT cycles
//
// FSM states:
//   IDLE     | strobe blank or invalid, waiting for a valid row
//   SETTLING | valid row seen, counting stable cycles
//   CAPTURED | row captured, waiting for the strobe/data to move on
module dotmatrix_scan_capture
  import scan_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ROWS-1:0]         row,
  input  logic [COLS-1:0]         col,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  output logic [COLS-1:0]         rd_data,
  output logic                    frame_valid,
  output logic                    frame_done,
  output logic                    row_err,
  output logic                    stale
);

  localparam int IW = $clog2(ROWS);
  localparam int SW = $clog2(SETTLE) + 1;

  logic [ROWS-1:0] row_q, row_prev;
  logic [COLS-1:0] col_q, col_prev;
  logic            err_d;
  logic            dec_valid, dec_blank, dec_err;
  logic [IW-1:0]   dec_idx;

  scan_state_t     state, state_n;
  logic [SW-1:0]   settle_cnt;
  logic            changed, settled, capture, settle_clr;

  logic [COLS-1:0] work   [ROWS];
  logic [COLS-1:0] shadow [ROWS];
  logic [ROWS-1:0] seen, seen_n;
  logic            frame_full;
  logic [31:0]     idle_cnt;

  onehot_row_decoder #(.ROWS(ROWS)) u_dec (
    .row   (row_q),
    .valid (dec_valid),
    .blank (dec_blank),
    .err   (dec_err),
    .idx   (dec_idx)
  );

  // Input sampling plus a one-cycle history used for change detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q    <= '1;
      col_q    <= '0;
      row_prev <= '1;
      col_prev <= '0;
      err_d    <= 1'b0;
      row_err  <= 1'b0;
    end else begin
      row_q    <= row;
      col_q    <= col;
      row_prev <= row_q;
      col_prev <= col_q;
      err_d    <= dec_err;
      row_err  <= dec_err & ~err_d;
    end
  end

  assign changed = (row_q != row_prev) || (col_q != col_prev);
  assign settled = (settle_cnt == SW'(SETTLE - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (dec_valid) state_n = SETTLING;
      SETTLING: begin
        if (changed)      state_n = (dec_blank || dec_err) ? IDLE : SETTLING;
        else if (settled) state_n = CAPTURED;
      end
      CAPTURED: if (changed) state_n = (dec_blank || dec_err) ? IDLE : SETTLING;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    capture    = (state == SETTLING) && !changed && settled;
    settle_clr = (state != SETTLING) || changed;
  end

  // Count stops at SETTLE-1 on the capture cycle; the FSM leaves SETTLING then.
  always_ff @(posedge clk) begin
    if (rst || settle_clr) settle_cnt <= '0;
    else if (!capture)     settle_cnt <= settle_cnt + SW'(1);
  end

  assign seen_n     = seen | (ROWS'(1) << dec_idx);
  assign frame_full = &seen_n;

  // The completing row is written straight into the shadow alongside the
  // older work rows, since work[] only takes it at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) begin
        work[i]   <= '0;
        shadow[i] <= '0;
      end
      seen        <= '0;
      frame_done  <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (capture) begin
        work[dec_idx] <= col_q;
        if (frame_full) begin
          for (int i = 0; i < ROWS; i++)
            shadow[i] <= (IW'(i) == dec_idx) ? col_q : work[i];
          seen        <= '0;
          frame_done  <= 1'b1;
          frame_valid <= 1'b1;
        end else begin
          seen <= seen_n;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                            idle_cnt <= '0;
    else if (capture)                   idle_cnt <= '0;
    else if (idle_cnt != 32'(TIMEOUT))  idle_cnt <= idle_cnt + 32'd1;
  end

  assign stale = (idle_cnt == 32'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= shadow[rd_row];
  end

endmodule
